// File: rtl/reg_skid_vr.sv
`default_nettype none
// ============================================================================
// Module      : reg_skid_vr
// Description : Two-entry valid/ready register slice with a skid buffer.
//               o_data comes straight from the main register and o_ready
//               depends only on registered state and reset, so upstream
//               never sees a combinational path from i_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_skid_vr #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic [DATA_WIDTH-1:0] main_reg;
  logic [DATA_WIDTH-1:0] skid_reg;
  logic                  in_fire;
  logic                  out_fire;

  // Handshake qualifiers; o_ready is already held low during reset, so no
  // input transfer is recognised in a reset cycle.
  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire) begin
          next_state = FULL;
        end else if (!in_fire && out_fire) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          next_state = BUSY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Output decode from registered state (plus reset for ready).
  always_comb begin
    o_valid = (state == BUSY) || (state == FULL);
    o_ready = ((state == EMPTY) || (state == BUSY)) && !i_rst;
    o_cnt   = state;
  end

  // Payload storage: main feeds the output, skid catches the word that
  // arrives while main is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_reg <= i_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_reg <= i_data;
          end else if (in_fire) begin
            skid_reg <= i_data;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_reg <= skid_reg;
          end
        end
        default: begin
          main_reg <= main_reg;
        end
      endcase
    end
  end

  assign o_data = main_reg;

endmodule
`default_nettype wire

// File: tb/tb_reg_skid_vr.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_skid_vr
// Description : Self-checking bench for reg_skid_vr; a queue-based model of
//               a two-deep FIFO supplies every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_skid_vr;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [1:0]  o_cnt;

  reg_skid_vr #(.DATA_WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_cnt   (o_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the words held by the slice, oldest first, plus the
  // value last presented on the output (held after draining to empty).
  logic [31:0] model_q[$];
  logic [31:0] shown    = '0;
  int          accepted = 0;
  int          delivered = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check ready, clock, update model, check.
  task automatic step(input logic rst, input logic v, input logic [31:0] d, input logic rdy);
    logic inf;
    logic outf;
    i_rst   = rst;
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    #1;
    check_eq("ready", 32'(o_ready), 32'(!rst && (model_q.size() < 2)));
    inf  = v && !rst && (model_q.size() < 2);
    outf = !rst && (model_q.size() > 0) && rdy;
    @(posedge i_clk);
    if (rst) begin
      model_q.delete();
      shown = '0;
    end else begin
      if (outf) begin
        void'(model_q.pop_front());
        delivered++;
      end
      if (inf) begin
        model_q.push_back(d);
        accepted++;
      end
      if (model_q.size() > 0) shown = model_q[0];
    end
    #1;
    check_eq("valid", 32'(o_valid), 32'(model_q.size() > 0));
    check_eq("cnt", 32'(o_cnt), 32'(model_q.size()));
    check_eq("data", o_data, shown);
  endtask

  initial begin
    int cycles;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;

    // Reset with a simultaneous would-be transfer.
    step(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("rst_data", o_data, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // Single word.
    step(1'b0, 1'b1, 32'hFFFF_0000, 1'b1);
    check_eq("single_data", o_data, 32'hFFFF_0000);
    check_eq("single_cnt", 32'(o_cnt), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("single_gone", 32'(o_valid), 32'd0);

    // Backpressure fill, then a refused third word.
    step(1'b0, 1'b1, 32'hA1, 1'b0);
    step(1'b0, 1'b1, 32'hB2, 1'b0);
    check_eq("fill_cnt", 32'(o_cnt), 32'd2);
    check_eq("fill_ready", 32'(o_ready), 32'd0);
    check_eq("fill_data", o_data, 32'hA1);
    step(1'b0, 1'b1, 32'hC3, 1'b0);
    check_eq("fill_hold", o_data, 32'hA1);

    // Drain from full.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("drain1_data", o_data, 32'hB2);
    check_eq("drain1_ready", 32'(o_ready), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("drain2_cnt", 32'(o_cnt), 32'd0);

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 32'(i), 1'b1);
      check_eq("stream_data", o_data, 32'(i));
      check_eq("stream_cnt", 32'(o_cnt), 32'd1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset while full discards both words.
    step(1'b0, 1'b1, 32'h55, 1'b0);
    step(1'b0, 1'b1, 32'h66, 1'b0);
    check_eq("pre_rst_cnt", 32'(o_cnt), 32'd2);
    step(1'b1, 1'b1, 32'h77, 1'b1);
    check_eq("rst_full_data", o_data, 32'h0);
    check_eq("rst_full_cnt", 32'(o_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check_eq("rst_full_novalid", 32'(o_valid), 32'd0);
    end

    // Random valid/ready traffic.
    accepted  = 0;
    delivered = 0;
    cycles    = 0;
    while (accepted < 1000 && cycles < 20000) begin
      step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0 ? 1 : 0));
      cycles++;
    end
    check_eq("rand_accepted", 32'(accepted), 32'd1000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    check_eq("rand_delivered", 32'(delivered), 32'(accepted));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
